alu_exec_ctrl: RTL and testbench

- Multi-cycle execute sequencer between the instruction decoder, the register file and the ALU datapath.
- Accepts one decoded data-processing instruction per handshake, evaluates its 4-bit condition field against the architectural NZCV register it owns, and reads operands.
- Drives the ALU execute strobe for exactly one cycle, writes the result back and commits flags when S is set.
- Sits between the control unit's decode stage and the ALU/register-file pair.

---
 rtl/alu_exec_ctrl_if.sv | 25 ++
 rtl/alu_exec_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Decoder-to-execute handshake: one decoded data-processing instruction per
// dec_valid/dec_ready transfer.
interface alu_exec_ctrl_if #(
   parameter int RADDR_W = 4
);
   logic               dec_valid;
   logic               dec_ready;
   logic [4:0]         dec_opcode;
   logic [3:0]         dec_cond;
   logic [RADDR_W-1:0] dec_rn;
   logic [RADDR_W-1:0] dec_rm;
   logic [RADDR_W-1:0] dec_rd;
   logic               dec_s;
   logic               dec_wb;

   modport master (
      output dec_valid, dec_opcode, dec_cond, dec_rn, dec_rm, dec_rd, dec_s, dec_wb,
      input  dec_ready
   );

   modport slave (
      input  dec_valid, dec_opcode, dec_cond, dec_rn, dec_rm, dec_rd, dec_s, dec_wb,
      output dec_ready
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Serial execute sequencer: condition check against owned NZCV, operand read,
// one-cycle ALU strobe, writeback and optional flag commit.
//
// state | meaning
// IDLE  | ready for a decoded instruction
// READ  | operands read from the register file; skipped instructions retire here
// EXEC  | ALU strobe; result captured, flags committed when S is set
// WB    | register-file write (if wb) and retire
module alu_exec_ctrl #(
   parameter int RADDR_W = 4,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_exec_ctrl_if.slave     dec,
   output logic [RADDR_W-1:0] rf_ra_addr,
   output logic [RADDR_W-1:0] rf_rb_addr,
   input  logic [DATA_W-1:0]  rf_ra_data,
   input  logic [DATA_W-1:0]  rf_rb_data,
   output logic               alu_execute,
   output logic [4:0]         alu_instruction,
   output logic [DATA_W-1:0]  alu_rn,
   output logic [DATA_W-1:0]  alu_rm,
   output logic [3:0]         alu_flags_in,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_n,
   input  logic               alu_z,
   input  logic               alu_c,
   input  logic               alu_v,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [3:0]         flags,
   output logic               busy,
   output logic               done,
   output logic               skipped
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t             state;
   logic [4:0]         opcode_q;
   logic [RADDR_W-1:0] rn_q;
   logic [RADDR_W-1:0] rm_q;
   logic [RADDR_W-1:0] rd_q;
   logic               s_q;
   logic               wb_q;
   logic               cond_ok_q;
   logic [DATA_W-1:0]  rn_data_q;
   logic [DATA_W-1:0]  rm_data_q;
   logic [DATA_W-1:0]  result_q;
   logic               accept_pass;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      logic r;
      {n, z, c, v} = nzcv;
      case (cond)
         4'd0:    r = z;
         4'd1:    r = !z;
         4'd2:    r = c;
         4'd3:    r = !c;
         4'd4:    r = n;
         4'd5:    r = !n;
         4'd6:    r = v;
         4'd7:    r = !v;
         4'd8:    r = c & !z;
         4'd9:    r = !c | z;
         4'd10:   r = (n == v);
         4'd11:   r = (n != v);
         4'd12:   r = !z & (n == v);
         4'd13:   r = z | (n != v);
         4'd14:   r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Flags cannot change between accept and READ, so the condition is resolved
   // at accept; that lets done/skipped for a failed check be registered in READ.
   assign accept_pass = cond_eval(dec.dec_cond, flags);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         flags       <= 4'b0000;
         opcode_q    <= '0;
         rn_q        <= '0;
         rm_q        <= '0;
         rd_q        <= '0;
         s_q         <= 1'b0;
         wb_q        <= 1'b0;
         cond_ok_q   <= 1'b0;
         rn_data_q   <= '0;
         rm_data_q   <= '0;
         result_q    <= '0;
         dec.dec_ready <= 1'b1;
         alu_execute <= 1'b0;
         rf_we       <= 1'b0;
         done        <= 1'b0;
         skipped     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dec.dec_valid && dec.dec_ready) begin
                  opcode_q      <= dec.dec_opcode;
                  rn_q          <= dec.dec_rn;
                  rm_q          <= dec.dec_rm;
                  rd_q          <= dec.dec_rd;
                  s_q           <= dec.dec_s;
                  wb_q          <= dec.dec_wb;
                  cond_ok_q     <= accept_pass;
                  done          <= !accept_pass;
                  skipped       <= !accept_pass;
                  dec.dec_ready <= 1'b0;
                  busy          <= 1'b1;
                  state         <= READ;
               end
            end
            READ: begin
               done    <= 1'b0;
               skipped <= 1'b0;
               if (cond_ok_q) begin
                  rn_data_q   <= rf_ra_data;
                  rm_data_q   <= rf_rb_data;
                  alu_execute <= 1'b1;
                  state       <= EXEC;
               end else begin
                  dec.dec_ready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            EXEC: begin
               alu_execute <= 1'b0;
               result_q    <= alu_result;
               if (s_q) begin
                  flags <= {alu_n, alu_z, alu_c, alu_v};
               end
               rf_we <= wb_q;
               done  <= 1'b1;
               state <= WB;
            end
            WB: begin
               rf_we         <= 1'b0;
               done          <= 1'b0;
               dec.dec_ready <= 1'b1;
               busy          <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign rf_ra_addr      = rn_q;
   assign rf_rb_addr      = rm_q;
   assign alu_instruction = opcode_q;
   assign alu_rn          = rn_data_q;
   assign alu_rm          = rm_data_q;
   assign alu_flags_in    = flags;
   assign rf_waddr        = rd_q;
   assign rf_wdata        = result_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed vector table, random instruction stream
// against a condition/flag model, and reset corner sequences.
module tb_alu_exec_ctrl;
   localparam int RADDR_W = 4;
   localparam int DATA_W  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_exec_ctrl_if #(.RADDR_W(RADDR_W)) dec_if ();

   logic [RADDR_W-1:0] rf_ra_addr, rf_rb_addr, rf_waddr;
   logic [DATA_W-1:0]  rf_ra_data, rf_rb_data, rf_wdata;
   logic               alu_execute, rf_we, busy, done, skipped;
   logic [4:0]         alu_instruction;
   logic [DATA_W-1:0]  alu_rn, alu_rm, alu_result;
   logic [3:0]         alu_flags_in, flags;
   logic               alu_n, alu_z, alu_c, alu_v;

   logic [DATA_W-1:0]  rf_mem [16];
   logic [DATA_W-1:0]  alu_res_v;
   logic [3:0]         alu_nzcv_v;

   assign rf_ra_data = rf_mem[rf_ra_addr];
   assign rf_rb_data = rf_mem[rf_rb_addr];
   assign alu_result = alu_res_v;
   assign {alu_n, alu_z, alu_c, alu_v} = alu_nzcv_v;

   alu_exec_ctrl #(.RADDR_W(RADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .dec(dec_if),
      .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
      .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
      .alu_execute(alu_execute), .alu_instruction(alu_instruction),
      .alu_rn(alu_rn), .alu_rm(alu_rm), .alu_flags_in(alu_flags_in),
      .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .flags(flags), .busy(busy), .done(done), .skipped(skipped)
   );

   int total = 0;
   int bad   = 0;
   logic [3:0] mflags;

   typedef struct {
      logic [4:0]  op;
      logic [3:0]  cond;
      logic [3:0]  rn, rm, rd;
      logic        s, wb;
      logic [31:0] res;
      logic [3:0]  nzcv;
      logic        exp_pass;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Conditions come in true/inverted pairs; cond[0] inverts the base test.
   function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic issue(input string tag, input logic [4:0] op, input logic [3:0] cond,
                        input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                        input logic s, input logic wb, input logic [31:0] res,
                        input logic [3:0] nzcv, input logic exp_pass, input logic [3:0] exp_flags);
      int done_cyc = 0, exec_cnt = 0, exec_cyc = 0, we_cnt = 0;
      logic [31:0] ex_rn = 'x, ex_rm = 'x, wd = 'x;
      logic [4:0]  ex_op = 'x;
      logic [3:0]  ex_fin = 'x, wa = 'x;
      logic        skp = 1'bx;
      @(negedge clk);
      check({tag, ".ready"}, dec_if.dec_ready, 1);
      dec_if.dec_valid  = 1'b1;
      dec_if.dec_opcode = op;
      dec_if.dec_cond   = cond;
      dec_if.dec_rn     = rn;
      dec_if.dec_rm     = rm;
      dec_if.dec_rd     = rd;
      dec_if.dec_s      = s;
      dec_if.dec_wb     = wb;
      alu_res_v         = res;
      alu_nzcv_v        = nzcv;
      @(posedge clk);
      #1;
      dec_if.dec_valid  = 1'b0;
      dec_if.dec_opcode = 5'($urandom);
      dec_if.dec_rn     = 4'($urandom);
      dec_if.dec_rm     = 4'($urandom);
      dec_if.dec_rd     = 4'($urandom);
      for (int cyc = 1; cyc <= 8 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) check({tag, ".busy"}, busy, 1);
         if (alu_execute) begin
            exec_cnt++;
            exec_cyc = cyc;
            ex_rn = alu_rn;
            ex_rm = alu_rm;
            ex_op = alu_instruction;
            ex_fin = alu_flags_in;
         end
         if (rf_we) begin
            we_cnt++;
            wa = rf_waddr;
            wd = rf_wdata;
         end
         if (done) begin
            done_cyc = cyc;
            skp = skipped;
         end
      end
      check({tag, ".done_cyc"}, done_cyc, exp_pass ? 3 : 1);
      check({tag, ".skipped"}, skp, !exp_pass);
      check({tag, ".exec_cnt"}, exec_cnt, exp_pass ? 1 : 0);
      check({tag, ".we_cnt"}, we_cnt, (exp_pass && wb) ? 1 : 0);
      check({tag, ".flags"}, flags, exp_flags);
      if (exp_pass) begin
         check({tag, ".exec_cyc"}, exec_cyc, 2);
         check({tag, ".alu_rn"}, ex_rn, rf_mem[rn]);
         check({tag, ".alu_rm"}, ex_rm, rf_mem[rm]);
         check({tag, ".alu_op"}, ex_op, op);
         check({tag, ".flags_in"}, ex_fin, mflags);
         if (wb) begin
            check({tag, ".waddr"}, wa, rd);
            check({tag, ".wdata"}, wd, res);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int stray;
      logic [3:0] cnd, nz, ef;
      logic s, wb, pass;
      for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
      alu_res_v  = '0;
      alu_nzcv_v = '0;

      // reset with a pending instruction: nothing may be accepted
      rst = 1'b1;
      dec_if.dec_valid = 1'b1; dec_if.dec_opcode = 5'd3; dec_if.dec_cond = 4'd14;
      dec_if.dec_rn = 4'd1; dec_if.dec_rm = 4'd2; dec_if.dec_rd = 4'd3;
      dec_if.dec_s = 1'b1; dec_if.dec_wb = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst.ready", dec_if.dec_ready, 1);
         check("rst.flags", flags, 4'b0000);
         check("rst.we", rf_we, 0);
         check("rst.done", done, 0);
         check("rst.busy", busy, 0);
         check("rst.exec", alu_execute, 0);
      end
      dec_if.dec_valid = 1'b0;
      rst = 1'b0;
      mflags = 4'b0000;

      //            op     cond   rn    rm    rd   s  wb  res            nzcv    pass flags
      tbl[0]  = '{5'd0,  4'd14, 4'd1, 4'd2, 4'd3, 1, 1, 32'h0000_0000, 4'b0100, 1, 4'b0100};
      tbl[1]  = '{5'd2,  4'd1,  4'd4, 4'd5, 4'd6, 1, 1, 32'h0000_0005, 4'b1111, 0, 4'b0100};
      tbl[2]  = '{5'd1,  4'd14, 4'd7, 4'd8, 4'd4, 1, 1, 32'hFFFF_FFFE, 4'b1000, 1, 4'b1000};
      tbl[3]  = '{5'd3,  4'd11, 4'd4, 4'd4, 4'd5, 0, 1, 32'h0000_1234, 4'b0000, 1, 4'b1000};
      tbl[4]  = '{5'd3,  4'd10, 4'd4, 4'd4, 4'd5, 1, 1, 32'h0000_4321, 4'b0001, 0, 4'b1000};
      tbl[5]  = '{5'd9,  4'd14, 4'd9, 4'd10, 4'd9, 0, 0, 32'h0000_DEAD, 4'b1111, 1, 4'b1000};
      tbl[6]  = '{5'd4,  4'd15, 4'd1, 4'd1, 4'd1, 1, 1, 32'h1111_1111, 4'b0000, 0, 4'b1000};
      tbl[7]  = '{5'd5,  4'd0,  4'd2, 4'd3, 4'd2, 1, 1, 32'h2222_2222, 4'b0000, 0, 4'b1000};
      tbl[8]  = '{5'd6,  4'd4,  4'd11, 4'd12, 4'd11, 1, 1, 32'h3333_3333, 4'b0010, 1, 4'b0010};
      tbl[9]  = '{5'd7,  4'd2,  4'd13, 4'd14, 4'd15, 1, 1, 32'h4444_4444, 4'b0011, 1, 4'b0011};
      tbl[10] = '{5'd8,  4'd8,  4'd15, 4'd0, 4'd0, 1, 1, 32'h5555_5555, 4'b0110, 1, 4'b0110};
      tbl[11] = '{5'd8,  4'd8,  4'd1, 4'd2, 4'd3, 1, 1, 32'h6666_6666, 4'b0000, 0, 4'b0110};
      tbl[12] = '{5'd10, 4'd9,  4'd3, 4'd6, 4'd7, 1, 1, 32'h7777_7777, 4'b1001, 1, 4'b1001};
      tbl[13] = '{5'd11, 4'd12, 4'd5, 4'd8, 4'd8, 1, 0, 32'h8888_8888, 4'b1000, 1, 4'b1000};
      tbl[14] = '{5'd12, 4'd13, 4'd6, 4'd9, 4'd10, 0, 1, 32'h9999_9999, 4'b0101, 1, 4'b1000};

      foreach (tbl[i]) begin
         issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].cond, tbl[i].rn, tbl[i].rm, tbl[i].rd,
               tbl[i].s, tbl[i].wb, tbl[i].res, tbl[i].nzcv, tbl[i].exp_pass, tbl[i].exp_flags);
         mflags = tbl[i].exp_flags;
      end

      for (int i = 0; i < 60; i++) begin
         cnd  = 4'($urandom);
         nz   = 4'($urandom);
         s    = 1'($urandom);
         wb   = 1'($urandom);
         pass = cond_model(mflags, cnd);
         ef   = (pass && s) ? nz : mflags;
         issue($sformatf("rnd%0d", i), 5'($urandom), cnd, 4'($urandom), 4'($urandom),
               4'($urandom), s, wb, $urandom, nz, pass, ef);
         mflags = ef;
      end

      // give flags a non-zero value so the reset below visibly clears them
      issue("pre_rst", 5'd1, 4'd14, 4'd2, 4'd3, 4'd4, 1, 1, 32'hA5A5_0000, 4'b1010, 1, 4'b1010);
      mflags = 4'b1010;

      // reset landing on the EXEC edge: no write, no done, flags cleared
      @(negedge clk);
      dec_if.dec_valid = 1'b1; dec_if.dec_opcode = 5'd2; dec_if.dec_cond = 4'd14;
      dec_if.dec_rn = 4'd1; dec_if.dec_rm = 4'd2; dec_if.dec_rd = 4'd5;
      dec_if.dec_s = 1'b1; dec_if.dec_wb = 1'b1;
      alu_res_v = 32'h0000_0055; alu_nzcv_v = 4'b0111;
      @(posedge clk);
      #1 dec_if.dec_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst.in_exec", alu_execute, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst.busy", busy, 0);
      check("mid_rst.ready", dec_if.dec_ready, 1);
      check("mid_rst.flags", flags, 4'b0000);
      check("mid_rst.exec", alu_execute, 0);
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         if (rf_we || done) stray++;
         @(negedge clk);
      end
      check("mid_rst.stray", stray, 0);
      mflags = 4'b0000;
      issue("post_rst", 5'd0, 4'd0, 4'd1, 4'd2, 4'd3, 1, 1, 32'h1, 4'b1111, 0, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
